// File: rtl/paddle_seq_pkg.sv
// paddle_seq_pkg: sequencer states, PIO register address and player indices for paddle_pio_sequencer
package paddle_seq_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;
   localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
   localparam int PLAYER0 = 0;
   localparam int PLAYER1 = 1;
endpackage

// File: rtl/paddle_axis.sv
// paddle_axis: one paddle position with clamped moves on tick; PADDLE_SEQ_ACCEL_EN adds a run counter that doubles the step
module paddle_axis #(
   parameter int POS_W       = 10,
   parameter int POS_MIN     = 0,
   parameter int POS_MAX     = 560,
   parameter int RESET_POS   = 280,
   parameter int STEP        = 4,
   parameter int ACCEL_TICKS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_i,
   input  logic             left_i,
   input  logic             right_i,
   output logic [POS_W-1:0] pos_o,
   output logic             moved_o
);
   localparam logic [POS_W-1:0] MIN_L = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0] MAX_L = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] STEP_L = POS_W'(STEP);
   if (ACCEL_TICKS < 1) begin : g_accel_chk
      $error("ACCEL_TICKS must be at least 1");
   end
   logic [POS_W-1:0] pos_q, pos_d, step;
   logic one_dir;
   assign one_dir = left_i ^ right_i;
`ifdef PADDLE_SEQ_ACCEL_EN
   localparam int RW = $clog2(ACCEL_TICKS + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(ACCEL_TICKS);
   logic [RW-1:0] run_q, run_d;
   logic dir_q, dir_d;
   assign run_d = !tick_i ? run_q
                : (!one_dir || (run_q != '0 && dir_q != right_i)) ? '0
                : (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
   assign dir_d = (tick_i && one_dir) ? right_i : dir_q;
   assign step = (run_q == RUN_MAX && dir_q == right_i) ? STEP_L << 1 : STEP_L;
   // Count consecutive same-direction move ticks (dir_q 1 = right)
   always_ff @(posedge clk) begin
      run_q <= reset ? '0 : run_d;
      dir_q <= reset ? 1'b0 : dir_d;
   end
`else
   assign step = STEP_L;
`endif
   // Compare against the limit before stepping so the position never wraps
   assign pos_d = (!tick_i || !one_dir) ? pos_q
                : left_i ? ((pos_q < MIN_L + step) ? MIN_L : pos_q - step)
                : ((pos_q > MAX_L - step) ? MAX_L : pos_q + step);
   assign moved_o = pos_d != pos_q;
   assign pos_o = pos_q;
   // Position register
   always_ff @(posedge clk) pos_q <= reset ? POS_W'(RESET_POS) : pos_d;
endmodule

// File: rtl/paddle_pio_sequencer.sv
// paddle_pio_sequencer: paddle positions from buttons, written round-robin to two PIO slaves; define PADDLE_SEQ_ACCEL_EN for acceleration
module paddle_pio_sequencer import paddle_seq_pkg::*; #(
   parameter int POS_W       = 10,
   parameter int POS_MIN     = 0,
   parameter int POS_MAX     = 560,
   parameter int RESET_POS   = 280,
   parameter int STEP        = 4,
   parameter int TICK_DIV    = 500000,
   parameter int ACCEL_TICKS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p0_left,
   input  logic             p0_right,
   input  logic             p1_left,
   input  logic             p1_right,
   output logic [1:0]       avm_address,
   output logic [1:0]       avm_chipselect,
   output logic             avm_write_n,
   output logic [31:0]      avm_writedata,
   output logic [POS_W-1:0] pos0,
   output logic [POS_W-1:0] pos1,
   output logic             busy
);
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   if (TICK_DIV < 2) begin : g_div_chk
      $error("TICK_DIV must be at least 2");
   end
   logic [CW-1:0] cnt_q;
   logic tick;
   assign tick = cnt_q == CNT_LAST;
   // Move-rate divider, wraps after TICK_DIV cycles
   always_ff @(posedge clk) cnt_q <= (reset || tick) ? '0 : cnt_q + 1'b1;
   logic [1:0] moved;
   paddle_axis #(.POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .RESET_POS(RESET_POS),
                 .STEP(STEP), .ACCEL_TICKS(ACCEL_TICKS)) u_axis0 (
      .clk(clk), .reset(reset), .tick_i(tick), .left_i(p0_left), .right_i(p0_right),
      .pos_o(pos0), .moved_o(moved[PLAYER0]));
   paddle_axis #(.POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .RESET_POS(RESET_POS),
                 .STEP(STEP), .ACCEL_TICKS(ACCEL_TICKS)) u_axis1 (
      .clk(clk), .reset(reset), .tick_i(tick), .left_i(p1_left), .right_i(p1_right),
      .pos_o(pos1), .moved_o(moved[PLAYER1]));
   state_t state_q;
   logic [1:0] pend_q, clr, cs_q;
   logic [POS_W-1:0] wd_q;
   logic last_q, sel, start, wn_q, busy_q;
   assign start = state_q == IDLE && pend_q != 2'b00;
   assign sel = (pend_q == 2'b11) ? ~last_q : pend_q[1];
   assign clr = start ? 2'b01 << sel : 2'b00;
   // Arbiter and write sequencer; a new move always wins over the clear of its pend flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= 2'b11;
         last_q  <= 1'b1;
         cs_q    <= 2'b00;
         wn_q    <= 1'b1;
         wd_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         pend_q <= (pend_q & ~clr) | moved;
         case (state_q)
            IDLE: if (start) begin
               state_q <= SETUP;
               last_q  <= sel;
               cs_q    <= 2'b01 << sel;
               wd_q    <= sel ? pos1 : pos0;
               busy_q  <= 1'b1;
            end
            SETUP: begin
               state_q <= WRITE;
               wn_q    <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               cs_q    <= 2'b00;
               wn_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
   assign avm_address = PIO_DATA_ADDR;
   assign avm_chipselect = cs_q;
   assign avm_write_n = wn_q;
   assign avm_writedata = {{(32-POS_W){1'b0}}, wd_q};
   assign busy = busy_q;
endmodule

// File: tb/tb_paddle_pio_sequencer.sv
// tb_paddle_pio_sequencer: vector table, directed multi-cycle sequences and random buttons against a behavioural model
module tb_paddle_pio_sequencer;
   localparam int TD = 4, AT = 2, S = 4, PMIN = 0, PMAX = 560, RP = 280;
   typedef struct {
      logic [3:0] btn;
      logic [1:0] cs;
      logic       wn;
      logic [9:0] wd;
      logic       busy;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1;
   logic p0_left = 1'b0, p0_right = 1'b0, p1_left = 1'b0, p1_right = 1'b0;
   logic [1:0] avm_address, avm_chipselect;
   logic avm_write_n, busy;
   logic [31:0] avm_writedata;
   logic [9:0] pos0, pos1;
   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;
   logic [11:0] wlog[$], wexp[$];
   int m_cnt = 0, m_phase = 0, m_g = 0, m_last = 1, m_data = 0, m_ticks = 0;
   int m_pos[2], m_run[2], m_dir[2];
   bit m_pend[2];

   always #5 clk = ~clk;

   paddle_pio_sequencer #(.TICK_DIV(TD), .ACCEL_TICKS(AT)) dut (
      .clk(clk), .reset(reset), .p0_left(p0_left), .p0_right(p0_right),
      .p1_left(p1_left), .p1_right(p1_right), .avm_address(avm_address),
      .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
      .avm_writedata(avm_writedata), .pos0(pos0), .pos1(pos1), .busy(busy));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: positions by clamped arithmetic, each write = 3 bus phases, grant to the pending player not served last
   always @(posedge clk) begin : model
      int np[2], lb[2], rb[2];
      bit st[2];
      bit tk;
      int d, stp;
      lb[0] = int'(p0_left); rb[0] = int'(p0_right);
      lb[1] = int'(p1_left); rb[1] = int'(p1_right);
      if (reset) begin
         m_cnt = 0; m_phase = 0; m_g = 0; m_last = 1; m_data = 0;
         m_pos = '{RP, RP}; m_pend = '{1'b1, 1'b1}; m_run = '{0, 0}; m_dir = '{0, 0};
      end else begin
         tk = (m_cnt == TD - 1);
         m_cnt = tk ? 0 : m_cnt + 1;
         m_ticks += int'(tk);
         for (int p = 0; p < 2; p++) begin
            np[p] = m_pos[p];
            st[p] = 1'b0;
`ifdef PADDLE_SEQ_ACCEL_EN
            if (tk && lb[p] == rb[p]) m_run[p] = 0;
`endif
            if (tk && lb[p] != rb[p]) begin
               d = rb[p] != 0 ? 1 : -1;
               stp = S;
`ifdef PADDLE_SEQ_ACCEL_EN
               if (m_run[p] == AT && m_dir[p] == d) stp = 2 * S;
               if (m_run[p] > 0 && m_dir[p] != d) m_run[p] = 0;
               else m_run[p] = m_run[p] < AT ? m_run[p] + 1 : AT;
               m_dir[p] = d;
`endif
               np[p] = d > 0 ? ((m_pos[p] + stp > PMAX) ? PMAX : m_pos[p] + stp)
                             : ((m_pos[p] - stp < PMIN) ? PMIN : m_pos[p] - stp);
               st[p] = np[p] != m_pos[p];
            end
         end
         if (m_phase == 0 && (m_pend[0] || m_pend[1])) begin
            m_g = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
            m_data = m_pos[m_g];
            m_pend[m_g] = 1'b0;
            m_last = m_g;
            m_phase = 1;
         end else m_phase = (m_phase == 0) ? 0 : (m_phase + 1) % 3;
         for (int p = 0; p < 2; p++) begin
            m_pos[p] = np[p];
            if (st[p]) m_pend[p] = 1'b1;
         end
      end
   end

   // Lockstep comparison every cycle plus a log of completed write strobes
   always @(negedge clk) begin : monitor
      logic [1:0] ecs;
      if (chk_en) begin
         ecs = (m_phase == 0) ? 2'b00 : (m_g == 1 ? 2'b10 : 2'b01);
         check("cycle", {avm_address, avm_chipselect, avm_write_n, avm_writedata, busy, pos0, pos1},
               {2'b00, ecs, m_phase != 2, 32'(m_data), m_phase != 0, 10'(m_pos[0]), 10'(m_pos[1])});
         if (!avm_write_n) wlog.push_back({avm_chipselect, avm_writedata[9:0]});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_ticks(input logic [3:0] b, input int n);
      int t0 = m_ticks;
      int k = 0;
      {p0_left, p0_right, p1_left, p1_right} = b;
      while (m_ticks < t0 + n && k < n * TD + 8) begin
         @(negedge clk);
         k++;
      end
      check("tick_wait", 64'(m_ticks - t0), 64'(n));
      {p0_left, p0_right, p1_left, p1_right} = 4'b0000;
   endtask

   task automatic check_log(input string nm);
      check({nm, "_count"}, 64'(wlog.size()), 64'(wexp.size()));
      for (int i = 0; i < wexp.size() && i < wlog.size(); i++) check(nm, 64'(wlog[i]), 64'(wexp[i]));
      wlog.delete();
      wexp.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      tbl[0] = '{4'b0000, 2'b01, 1'b1, 10'd280, 1'b1};
      tbl[1] = '{4'b0000, 2'b01, 1'b0, 10'd280, 1'b1};
      tbl[2] = '{4'b0000, 2'b00, 1'b1, 10'd280, 1'b0};
      tbl[3] = '{4'b0000, 2'b10, 1'b1, 10'd280, 1'b1};
      tbl[4] = '{4'b0000, 2'b10, 1'b0, 10'd280, 1'b1};
      tbl[5] = '{4'b0000, 2'b00, 1'b1, 10'd280, 1'b0};
      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_cs", avm_chipselect, 2'b00);
      check("rst_wn", avm_write_n, 1'b1);
      check("rst_wd", avm_writedata, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_pos", {pos0, pos1}, {10'd280, 10'd280});
      reset = 1'b0;
      foreach (tbl[i]) begin
         {p0_left, p0_right, p1_left, p1_right} = tbl[i].btn;
         @(negedge clk);
         check($sformatf("tbl%0d_cs", i), avm_chipselect, tbl[i].cs);
         check($sformatf("tbl%0d_wn", i), avm_write_n, tbl[i].wn);
         check($sformatf("tbl%0d_wd", i), avm_writedata, tbl[i].wd);
         check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         check($sformatf("tbl%0d_pos0", i), pos0, 10'd280);
      end
      idle(4);
      wlog.delete();
`ifdef PADDLE_SEQ_ACCEL_EN
      run_ticks(4'b0100, 4);
      idle(8);
      wexp = '{{2'b01, 10'd284}, {2'b01, 10'd288}, {2'b01, 10'd296}, {2'b01, 10'd304}};
      check_log("accel_run");
      run_ticks(4'b0100, 1);
      idle(8);
      wexp = '{{2'b01, 10'd308}};
      check_log("accel_repress");
`else
      run_ticks(4'b0100, 3);
      idle(8);
      wexp = '{{2'b01, 10'd284}, {2'b01, 10'd288}, {2'b01, 10'd292}};
      check_log("p0_right3");
      check("p0_right3_pos", pos0, 10'd292);
      run_ticks(4'b0101, 1);
      idle(8);
      wexp = '{{2'b10, 10'd284}, {2'b01, 10'd296}};
      check_log("both_last0");
      run_ticks(4'b0001, 1);
      idle(8);
      wexp = '{{2'b10, 10'd288}};
      check_log("p1_alone");
      run_ticks(4'b0101, 1);
      idle(8);
      wexp = '{{2'b01, 10'd300}, {2'b10, 10'd292}};
      check_log("both_last1");
      run_ticks(4'b0101, 1);
      run_ticks(4'b0001, 1);
      idle(10);
      wexp = '{{2'b01, 10'd304}, {2'b10, 10'd296}, {2'b10, 10'd300}};
      check_log("setup_entry_move");
      run_ticks(4'b0101, 1);
      run_ticks(4'b0011, 1);
      idle(10);
      wexp = '{{2'b01, 10'd308}, {2'b10, 10'd304}};
      check_log("setup_entry_both");
      run_ticks(4'b0100, 62);
      idle(8);
      wlog.delete();
      run_ticks(4'b0100, 1);
      idle(8);
      wexp = '{{2'b01, 10'd560}};
      check_log("clamp_hi");
      run_ticks(4'b0100, 1);
      idle(8);
      check_log("clamp_hi_hold");
      check("clamp_hi_pos", pos0, 10'd560);
      run_ticks(4'b1000, 139);
      idle(8);
      wlog.delete();
      run_ticks(4'b1000, 1);
      idle(8);
      wexp = '{{2'b01, 10'd0}};
      check_log("clamp_lo");
      run_ticks(4'b1000, 1);
      idle(8);
      check_log("clamp_lo_hold");
      check("clamp_lo_pos", pos0, 10'd0);
`endif
      run_ticks(4'b0100, 1);
      @(negedge clk);
      check("abort_setup_cs", avm_chipselect, 2'b01);
      @(negedge clk);
      check("abort_write_wn", avm_write_n, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("abort_cs", avm_chipselect, 2'b00);
      check("abort_wn", avm_write_n, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_pos0", pos0, 10'd280);
      reset = 1'b0;
      idle(8);
      wlog.delete();
      repeat (300) begin
         {p0_left, p0_right, p1_left, p1_right} = 4'($urandom);
         idle($urandom_range(1, 12));
      end
      {p0_left, p0_right, p1_left, p1_right} = 4'b0000;
      idle(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
